line_draw_engine: RTL

Bresenham line rasteriser that sits directly upstream of the VGA adapter (160x120, 3-bit colour). It accepts two endpoints and a colour from the control FSM and emits one pixel per clock on x_out/y_out/colour_out with a plot strobe that drives the adapter's plot input. It handles all octants and suppresses plots that fall off-screen.

---
 rtl/line_pkg.sv | 17 +
 rtl/bres_step.sv | 40 ++++
 rtl/line_draw_engine.sv | 135 +++++++++++++
 3 files changed

// File: rtl/line_pkg.sv
// Shared types and screen constants for the line rasteriser and its step logic.
package line_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    typedef logic [2:0] colour_t;
    typedef logic signed [9:0] err_t;

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        DRAW,
        DONE
    } state_t;

endpackage

// File: rtl/bres_step.sv
// One Bresenham iteration: advances the current point and error term.
module bres_step
    import line_pkg::*;
#(
    parameter int X_W = 8,
    parameter int Y_W = 7
) (
    input  logic [X_W-1:0] cur_x,
    input  logic [Y_W-1:0] cur_y,
    input  err_t           err,
    input  err_t           dx,
    input  err_t           dy,
    input  logic           sx_neg,
    input  logic           sy_neg,
    output logic [X_W-1:0] nxt_x,
    output logic [Y_W-1:0] nxt_y,
    output err_t           nxt_err
);

    err_t e2;
    err_t err_acc;

    always_comb begin
        e2      = err <<< 1;
        err_acc = err;
        nxt_x   = cur_x;
        nxt_y   = cur_y;
        // Both tests use the pre-update e2, so a diagonal step applies both increments.
        if (e2 >= dy) begin
            err_acc = err_acc + dy;
            nxt_x   = sx_neg ? cur_x - 1'b1 : cur_x + 1'b1;
        end
        if (e2 <= dx) begin
            err_acc = err_acc + dx;
            nxt_y   = sy_neg ? cur_y - 1'b1 : cur_y + 1'b1;
        end
        nxt_err = err_acc;
    end

endmodule

// File: rtl/line_draw_engine.sv
// Bresenham line rasteriser feeding the VGA adapter, one pixel per clock with clipping.
//
//   state | meaning
//   IDLE  | waiting for start; endpoints and colour latched on start
//   INIT  | derive dx, dy, step directions and initial error
//   DRAW  | emit current pixel, advance until the end point is emitted
//   DONE  | last pixel on outputs, done pulse, then back to IDLE
module line_draw_engine
    import line_pkg::*;
#(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int SCREEN_W = line_pkg::SCREEN_W,
    parameter int SCREEN_H = line_pkg::SCREEN_H
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           start,
    input  logic [X_W-1:0] x0,
    input  logic [Y_W-1:0] y0,
    input  logic [X_W-1:0] x1,
    input  logic [Y_W-1:0] y1,
    input  colour_t        colour_in,
    output logic [X_W-1:0] x_out,
    output logic [Y_W-1:0] y_out,
    output colour_t        colour_out,
    output logic           plot,
    output logic           busy,
    output logic           done
);

    state_t         state, state_nxt;
    logic [X_W-1:0] lx0, lx1, cur_x, nxt_x;
    logic [Y_W-1:0] ly0, ly1, cur_y, nxt_y;
    colour_t        lcol;
    err_t           err, dx, dy, nxt_err;
    err_t           diff_x, diff_y, abs_dx, abs_dy;
    logic           sx_neg, sy_neg;
    logic           at_end, on_screen;

    always_comb begin
        diff_x    = err_t'(lx1) - err_t'(lx0);
        diff_y    = err_t'(ly1) - err_t'(ly0);
        abs_dx    = diff_x[9] ? -diff_x : diff_x;
        abs_dy    = diff_y[9] ? -diff_y : diff_y;
        at_end    = (cur_x == lx1) && (cur_y == ly1);
        on_screen = (int'(cur_x) < SCREEN_W) && (int'(cur_y) < SCREEN_H);
    end

    bres_step #(.X_W(X_W), .Y_W(Y_W)) u_step (
        .cur_x  (cur_x),
        .cur_y  (cur_y),
        .err    (err),
        .dx     (dx),
        .dy     (dy),
        .sx_neg (sx_neg),
        .sy_neg (sy_neg),
        .nxt_x  (nxt_x),
        .nxt_y  (nxt_y),
        .nxt_err(nxt_err)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = INIT;
            INIT:    state_nxt = DRAW;
            DRAW:    if (at_end) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lx0        <= '0;
            ly0        <= '0;
            lx1        <= '0;
            ly1        <= '0;
            lcol       <= '0;
            cur_x      <= '0;
            cur_y      <= '0;
            err        <= '0;
            dx         <= '0;
            dy         <= '0;
            sx_neg     <= 1'b0;
            sy_neg     <= 1'b0;
            x_out      <= '0;
            y_out      <= '0;
            colour_out <= '0;
            plot       <= 1'b0;
        end else begin
            plot <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    lx0  <= x0;
                    ly0  <= y0;
                    lx1  <= x1;
                    ly1  <= y1;
                    lcol <= colour_in;
                end
                INIT: begin
                    dx     <= abs_dx;
                    dy     <= -abs_dy;
                    sx_neg <= (lx1 < lx0);
                    sy_neg <= (ly1 < ly0);
                    err    <= abs_dx - abs_dy;
                    cur_x  <= lx0;
                    cur_y  <= ly0;
                end
                DRAW: begin
                    x_out      <= cur_x;
                    y_out      <= cur_y;
                    colour_out <= lcol;
                    plot       <= on_screen;
                    if (!at_end) begin
                        cur_x <= nxt_x;
                        cur_y <= nxt_y;
                        err   <= nxt_err;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
